ps2_text_display: RTL and testbench

Multi-digit PS/2 text entry buffer for the seven-segment bank. It consumes raw PS/2 scancode bytes and handles break (F0) and extended (E0) prefixes. Make codes for letters, digits and control keys are translated into active-low segment patterns and kept in an NUM_DIGITS-deep shift buffer. It sits between the PS/2 receiver and the HEX outputs, and generalises the single-digit letter decoder to a registered, editable, parametrised display.

---
 rtl/ps2_text_display_if.sv | 27 ++
 rtl/ps2_text_display.sv | 140 ++++++++++++++
 tb/tb_ps2_text_display.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_text_display_if.sv
// PS/2 text display bus: scancode strobe and wrap control in, segment bank and status out.
// Latency: none (wires only).
// Backpressure: none; the receiver side never stalls, every strobe is consumed.
interface ps2_text_display_if #(
  parameter int NUM_DIGITS = 6,
  parameter int CNT_W      = 3
);
  logic [7:0]              scan_code;
  logic                    scan_valid;
  logic                    wrap_en;
  logic [7*NUM_DIGITS-1:0] hex_out;
  logic [CNT_W-1:0]        char_count;
  logic                    full;
  logic                    key_event;

  // Receiver side: drives scancodes and wrap mode, observes the display
  modport master (
    output scan_code, scan_valid, wrap_en,
    input  hex_out, char_count, full, key_event
  );

  // Display side: consumes scancodes, drives segments and status
  modport slave (
    input  scan_code, scan_valid, wrap_en,
    output hex_out, char_count, full, key_event
  );
endinterface

// File: rtl/ps2_text_display.sv
// Editable multi-digit text buffer fed by raw PS/2 scancodes, driving active-low seven-segment digits.
// Latency: 1 cycle from scan_valid strobe to buffer update and key_event pulse.
// Backpressure: none; one byte per strobe, back-to-back strobes processed in order.
module ps2_text_display #(
  parameter int NUM_DIGITS = 6,
  parameter int CNT_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  ps2_text_display_if.slave bus
);

  localparam int                HW      = 7 * NUM_DIGITS;
  localparam logic [6:0]        BLANK   = 7'h7F;
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(NUM_DIGITS);
  localparam logic [7:0]        SC_BRK  = 8'hF0;
  localparam logic [7:0]        SC_EXT  = 8'hE0;
  localparam logic [7:0]        SC_BS   = 8'h66;
  localparam logic [7:0]        SC_ESC  = 8'h76;

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

  state_t           state;
  logic [HW-1:0]    hex_q;
  logic [HW-1:0]    hex_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             key_q;
  logic             is_char;
  logic [6:0]       pat;

  // Translate a make code into its segment pattern (space is a blank character)
  always_comb begin
    is_char = 1'b1;
    pat     = BLANK;
    case (bus.scan_code)
      8'h1C: pat = 7'b0001000;
      8'h32: pat = 7'b0000011;
      8'h21: pat = 7'b1000110;
      8'h23: pat = 7'b0100001;
      8'h24: pat = 7'b0000110;
      8'h2B: pat = 7'b0001110;
      8'h34: pat = 7'b1000010;
      8'h33: pat = 7'b0001001;
      8'h43: pat = 7'b1001111;
      8'h3B: pat = 7'b1100001;
      8'h42: pat = 7'b0001011;
      8'h4B: pat = 7'b1000111;
      8'h3A: pat = 7'b0010101;
      8'h31: pat = 7'b1101010;
      8'h44: pat = 7'b1100010;
      8'h4D: pat = 7'b0011000;
      8'h15: pat = 7'b0001100;
      8'h2D: pat = 7'b1111010;
      8'h1B: pat = 7'b0100100;
      8'h2C: pat = 7'b1110000;
      8'h3C: pat = 7'b1000001;
      8'h2A: pat = 7'b1010101;
      8'h1D: pat = 7'b1000000;
      8'h22: pat = 7'b0110110;
      8'h35: pat = 7'b1000100;
      8'h1A: pat = 7'b0010010;
      8'h16: pat = 7'b1111001;
      8'h1E: pat = 7'b0100100;
      8'h26: pat = 7'b0110000;
      8'h25: pat = 7'b0011001;
      8'h2E: pat = 7'b0010010;
      8'h36: pat = 7'b0000010;
      8'h3D: pat = 7'b1111000;
      8'h3E: pat = 7'b0000000;
      8'h46: pat = 7'b0010000;
      8'h45: pat = 7'b1000000;
      8'h29: pat = BLANK;
      default: is_char = 1'b0;
    endcase
  end

  // Next buffer contents; only plain make codes seen in IDLE can edit the buffer
  always_comb begin
    hex_nxt = hex_q;
    cnt_nxt = cnt_q;
    if (bus.scan_valid && state == IDLE) begin
      if (bus.scan_code == SC_BS) begin
        if (cnt_q != '0) begin
          hex_nxt = {BLANK, hex_q[HW-1:7]};
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end else if (bus.scan_code == SC_ESC) begin
        if (cnt_q != '0) begin
          hex_nxt = {NUM_DIGITS{BLANK}};
          cnt_nxt = '0;
        end
      end else if (is_char) begin
        if (cnt_q != MAX_CNT) begin
          hex_nxt = {hex_q[HW-8:0], pat};
          cnt_nxt = cnt_q + CNT_W'(1);
        end else if (bus.wrap_en) begin
          hex_nxt = {hex_q[HW-8:0], pat};
        end
      end
    end
  end

  // Prefix FSM plus registered buffer; key_event flags any visible change
  // (a wrap that shifts identical patterns produces no event)
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hex_q <= {NUM_DIGITS{BLANK}};
      cnt_q <= '0;
      key_q <= 1'b0;
    end else begin
      hex_q <= hex_nxt;
      cnt_q <= cnt_nxt;
      key_q <= (hex_nxt != hex_q) || (cnt_nxt != cnt_q);
      if (bus.scan_valid) begin
        case (state)
          IDLE: begin
            if (bus.scan_code == SC_BRK)      state <= BREAK;
            else if (bus.scan_code == SC_EXT) state <= EXT;
            else                              state <= IDLE;
          end
          EXT: begin
            if (bus.scan_code == SC_BRK) state <= EXT_BREAK;
            else                         state <= IDLE;
          end
          BREAK:     state <= IDLE;
          EXT_BREAK: state <= IDLE;
          default:   state <= IDLE;
        endcase
      end
    end
  end

  assign bus.hex_out    = hex_q;
  assign bus.char_count = cnt_q;
  assign bus.full       = (cnt_q == MAX_CNT);
  assign bus.key_event  = key_q;

endmodule

// File: tb/tb_ps2_text_display.sv
// Self-checking bench for ps2_text_display: directed scenarios followed by randomized byte streams.
// Expected values come from a queue-based model of the text buffer and prefix handling.
module tb_ps2_text_display;

  localparam int N  = 6;
  localparam int CW = 3;

  logic clk;
  logic reset;

  ps2_text_display_if #(.NUM_DIGITS(N), .CNT_W(CW)) bus ();

  ps2_text_display #(.NUM_DIGITS(N), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Model: characters held newest-first, plus pending-prefix flags
  logic [6:0] mq[$];
  bit         m_skip_next;
  bit         m_ext;

  logic [7:0] pool[37] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                           8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                           8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h16,
                           8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
                           8'h29};

  // Character table: returns pattern, or -1 when the byte is not a character
  function automatic int decode(input logic [7:0] c);
    case (c)
      8'h1C: return 7'b0001000;  8'h32: return 7'b0000011;  8'h21: return 7'b1000110;
      8'h23: return 7'b0100001;  8'h24: return 7'b0000110;  8'h2B: return 7'b0001110;
      8'h34: return 7'b1000010;  8'h33: return 7'b0001001;  8'h43: return 7'b1001111;
      8'h3B: return 7'b1100001;  8'h42: return 7'b0001011;  8'h4B: return 7'b1000111;
      8'h3A: return 7'b0010101;  8'h31: return 7'b1101010;  8'h44: return 7'b1100010;
      8'h4D: return 7'b0011000;  8'h15: return 7'b0001100;  8'h2D: return 7'b1111010;
      8'h1B: return 7'b0100100;  8'h2C: return 7'b1110000;  8'h3C: return 7'b1000001;
      8'h2A: return 7'b1010101;  8'h1D: return 7'b1000000;  8'h22: return 7'b0110110;
      8'h35: return 7'b1000100;  8'h1A: return 7'b0010010;
      8'h16: return 7'b1111001;  8'h1E: return 7'b0100100;  8'h26: return 7'b0110000;
      8'h25: return 7'b0011001;  8'h2E: return 7'b0010010;  8'h36: return 7'b0000010;
      8'h3D: return 7'b1111000;  8'h3E: return 7'b0000000;  8'h46: return 7'b0010000;
      8'h45: return 7'b1000000;
      8'h29: return 7'b1111111;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7*N-1:0] exp_hex();
    logic [7*N-1:0] v;
    v = '1;
    for (int k = 0; k < mq.size(); k++) v[7*k +: 7] = mq[k];
    return v;
  endfunction

  task automatic model_byte(input logic [7:0] c, input logic wr);
    int p;
    p = decode(c);
    if (m_skip_next) begin
      m_skip_next = 0;
    end else if (m_ext) begin
      m_ext = 0;
      if (c == 8'hF0) m_skip_next = 1;
    end else if (c == 8'hF0) begin
      m_skip_next = 1;
    end else if (c == 8'hE0) begin
      m_ext = 1;
    end else if (c == 8'h66) begin
      if (mq.size() > 0) void'(mq.pop_front());
    end else if (c == 8'h76) begin
      mq.delete();
    end else if (p >= 0) begin
      if (mq.size() < N) begin
        mq.push_front(7'(p));
      end else if (wr) begin
        mq.push_front(7'(p));
        void'(mq.pop_back());
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input logic exp_key);
    chk("hex_out", 64'(bus.hex_out), 64'(exp_hex()));
    chk("char_count", 64'(bus.char_count), 64'(mq.size()));
    chk("full", 64'(bus.full), 64'(mq.size() == N));
    chk("key_event", 64'(bus.key_event), 64'(exp_key));
  endtask

  // One clock with optional strobe; outputs checked 1 time unit after the edge
  task automatic step(input bit v, input logic [7:0] c);
    logic [7*N-1:0] old_hex;
    int             old_cnt;
    logic           ek;
    bus.scan_valid = v;
    bus.scan_code  = c;
    old_hex = exp_hex();
    old_cnt = mq.size();
    @(posedge clk);
    #1;
    if (v) model_byte(c, bus.wrap_en);
    ek = (exp_hex() != old_hex) || (mq.size() != old_cnt);
    check_all(ek);
    bus.scan_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.scan_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    m_skip_next = 0;
    m_ext = 0;
    check_all(1'b0);
  endtask

  initial begin
    logic [7:0] c;
    int r;
    reset          = 1'b1;
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
    bus.wrap_en    = 1'b0;
    m_skip_next    = 0;
    m_ext          = 0;

    // Reset state
    do_reset();
    chk("rst_hex_blank", 64'(bus.hex_out), 64'({N{7'h7F}}));

    // Make, break of same key: one character, one event
    step(1, 8'h1C);
    chk("a_make_event", 64'(bus.key_event), 64'd1);
    step(1, 8'hF0);
    step(1, 8'h1C);
    chk("a_digit0", 64'(bus.hex_out[6:0]), 64'(7'b0001000));
    chk("a_count", 64'(bus.char_count), 64'd1);

    // E, 1, space, then backspace
    do_reset();
    step(1, 8'h24);
    step(1, 8'h16);
    step(1, 8'h29);
    chk("e1s_low21", 64'(bus.hex_out[20:0]), 64'({7'b0000110, 7'b1111001, 7'b1111111}));
    step(1, 8'h66);
    chk("bs_low14", 64'(bus.hex_out[13:0]), 64'({7'b0000110, 7'b1111001}));
    chk("bs_count", 64'(bus.char_count), 64'd2);

    // Overflow with wrap disabled, then enabled
    do_reset();
    bus.wrap_en = 1'b0;
    foreach (pool[i]) if (i < 7) step(1, pool[(i < 6) ? i : 6]);
    chk("nowrap_event", 64'(bus.key_event), 64'd0);
    chk("nowrap_full", 64'(bus.full), 64'd1);
    do_reset();
    bus.wrap_en = 1'b1;
    foreach (pool[i]) if (i < 7) step(1, pool[i]);
    chk("wrap_d0_g", 64'(bus.hex_out[6:0]), 64'(7'b1000010));
    chk("wrap_d5_b", 64'(bus.hex_out[41:35]), 64'(7'b0000011));
    bus.wrap_en = 1'b0;

    // Extended sequences and backspace on empty buffer
    do_reset();
    step(1, 8'hE0); step(1, 8'h6B);
    step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h6B);
    step(1, 8'h66);
    step(1, 8'hAA); step(1, 8'hFA); step(1, 8'hFE); step(1, 8'hEE);

    // Reset clears a pending break prefix
    step(1, 8'h32); step(1, 8'h21); step(1, 8'h23);
    step(1, 8'hF0);
    do_reset();
    step(1, 8'h1C);
    chk("prefix_cleared", 64'(bus.char_count), 64'd1);

    // Escape with content, then on empty buffer
    step(1, 8'h32); step(1, 8'h21); step(1, 8'h23);
    step(1, 8'h76);
    chk("esc_event", 64'(bus.key_event), 64'd1);
    step(1, 8'h76);
    chk("esc_empty_event", 64'(bus.key_event), 64'd0);

    // Randomized byte stream, mixing idles, prefixes, edits and resets
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 19) == 0) bus.wrap_en = ~bus.wrap_en;
      if (r < 2) begin
        do_reset();
      end else if (r < 10) begin
        step(0, 8'(($urandom_range(0, 255))));
      end else begin
        r = $urandom_range(0, 39);
        if (r < 3)       c = 8'hF0;
        else if (r < 5)  c = 8'hE0;
        else if (r < 9)  c = 8'h66;
        else if (r < 10) c = 8'h76;
        else if (r < 12) c = 8'($urandom_range(0, 255));
        else             c = pool[$urandom_range(0, 36)];
        step(1, c);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
